// File: rtl/sram_req_arbiter_pkg.sv
// Shared types for the SRAM request arbiter: requester ids, order-queue entry and grant FSM states.
package sram_req_arbiter_pkg;

  localparam logic REQ_ID_INST = 1'b0;
  localparam logic REQ_ID_DATA = 1'b1;

  typedef struct packed {
    logic id;
    logic discard;
  } qent_t;

  localparam int QENT_W = $bits(qent_t);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOCK_INST = 2'd1,
    ST_LOCK_DATA = 2'd2
  } arb_state_e;

endpackage

// File: rtl/sram_req_arbiter_order_queue.sv
// Circular FIFO of {id, discard} entries, one per accepted memory transaction.
// A push at full is taken only when a pop happens in the same cycle.
module sram_req_arbiter_order_queue
  import sram_req_arbiter_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  i_push,
  input  qent_t i_push_ent,
  input  logic  i_pop,
  input  logic  i_set_discard_inst,
  output logic  o_full,
  output logic  o_empty,
  output qent_t o_head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  qent_t            r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;

  logic w_pop_ok;
  logic w_push_ok;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == FULL_CNT);
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);
  assign o_head    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // Stale slots may get their discard bit set too; a later push overwrites them.
      if (i_set_discard_inst) begin
        for (int i = 0; i < DEPTH; i++)
          if (r_mem[i].id == REQ_ID_INST) r_mem[i].discard <= 1'b1;
      end
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= i_push_ent;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop_ok) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count <= r_count + {{PTR_W{1'b0}}, w_push_ok} - {{PTR_W{1'b0}}, w_pop_ok};
    end
  end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between fetch and load/store; grant held until address accept, responses routed in order.
// Build option ARB_ROUND_ROBIN_EN alternates priority between requesters; otherwise data beats inst.
module sram_req_arbiter
  import sram_req_arbiter_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              inst_req,
  input  logic [ADDR_W-1:0] inst_addr,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [31:0]       inst_rdata,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [3:0]        data_wstrb,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [31:0]       data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [31:0]       data_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata
);

  arb_state_e r_state;
  arb_state_e w_state_nxt;

  logic  w_gnt;
  logic  w_sel_req;
  logic  w_mem_req;
  logic  w_hs;
  logic  w_room;
  logic  w_pop;
  logic  w_full;
  logic  w_empty;
  qent_t w_head;
  qent_t w_push_ent;

`ifdef ARB_ROUND_ROBIN_EN
  logic r_last_grant;

  always_ff @(posedge clk) begin
    if (reset)     r_last_grant <= REQ_ID_INST;
    else if (w_hs) r_last_grant <= w_gnt;
  end
`endif

  // A response retiring this cycle frees a slot for a same-cycle accept.
  assign w_pop  = mem_data_ok & ~w_empty;
  assign w_room = ~w_full | w_pop;
  assign w_hs   = w_mem_req & mem_addr_ok;

  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_mem_req && !mem_addr_ok)
          w_state_nxt = (w_gnt == REQ_ID_DATA) ? ST_LOCK_DATA : ST_LOCK_INST;
      end
      ST_LOCK_INST: begin
        if (w_hs || (flush && !w_mem_req)) w_state_nxt = ST_IDLE;
      end
      ST_LOCK_DATA: begin
        if (w_hs) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_gnt     = REQ_ID_DATA;
    w_sel_req = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (data_req && inst_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          w_gnt = ~r_last_grant;
`else
          w_gnt = REQ_ID_DATA;
`endif
        end else if (inst_req) begin
          w_gnt = REQ_ID_INST;
        end
        w_sel_req = data_req | inst_req;
      end
      ST_LOCK_INST: begin
        w_gnt     = REQ_ID_INST;
        w_sel_req = inst_req;
      end
      ST_LOCK_DATA: begin
        w_gnt     = REQ_ID_DATA;
        w_sel_req = data_req;
      end
      default: ;
    endcase
    w_mem_req = w_sel_req & w_room;

    mem_req   = w_mem_req;
    mem_wr    = w_mem_req & (w_gnt == REQ_ID_DATA) & data_wr;
    mem_wstrb = mem_wr ? data_wstrb : 4'b0;
    mem_wdata = mem_wr ? data_wdata : 32'b0;
    mem_addr  = '0;
    if (w_mem_req) mem_addr = (w_gnt == REQ_ID_DATA) ? data_addr : inst_addr;

    inst_addr_ok = w_hs & (w_gnt == REQ_ID_INST);
    data_addr_ok = w_hs & (w_gnt == REQ_ID_DATA);
  end

  assign w_push_ent.id      = w_gnt;
  assign w_push_ent.discard = (w_gnt == REQ_ID_INST) & flush;

  sram_req_arbiter_order_queue #(
    .DEPTH (MAX_OUTSTANDING)
  ) u_order_queue (
    .clk                (clk),
    .reset              (reset),
    .i_push             (w_hs),
    .i_push_ent         (w_push_ent),
    .i_pop              (mem_data_ok),
    .i_set_discard_inst (flush),
    .o_full             (w_full),
    .o_empty            (w_empty),
    .o_head             (w_head)
  );

  assign data_data_ok = w_pop & (w_head.id == REQ_ID_DATA);
  assign inst_data_ok = w_pop & (w_head.id == REQ_ID_INST) & ~w_head.discard;
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter: arbitration, lock, full, flush discard and reset cases.
module tb_sram_req_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic        data_wr;
  logic [3:0]  data_wstrb;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;
  logic        mem_req;
  logic        mem_wr;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_addr_ok;
  logic        mem_data_ok;
  logic [31:0] mem_rdata;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sram_req_arbiter #(
    .MAX_OUTSTANDING (2),
    .ADDR_W          (32)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .inst_req     (inst_req),
    .inst_addr    (inst_addr),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .mem_req      (mem_req),
    .mem_wr       (mem_wr),
    .mem_wstrb    (mem_wstrb),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_addr_ok  (mem_addr_ok),
    .mem_data_ok  (mem_data_ok),
    .mem_rdata    (mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic exp_rr [4];

  initial begin
    reset = 1'b1; flush = 1'b0;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = '0;
    step(); step();
    reset = 1'b0;
    #1;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_addr_oks", {inst_addr_ok, data_addr_ok}, 0);
    chk("rst_data_oks", {inst_data_ok, data_data_ok}, 0);
    chk("rst_mem_fields", {mem_wr, mem_wstrb, mem_addr[26:0]}, 0);
    step();

    // Simultaneous requests: data first, then inst; responses in order.
    inst_req = 1'b1; inst_addr = 32'h100;
    data_req = 1'b1; data_wr = 1'b0; data_addr = 32'h200;
    mem_addr_ok = 1'b1;
    #1;
    chk("prio_data_addr_ok", data_addr_ok, 1);
    chk("prio_inst_addr_ok0", inst_addr_ok, 0);
    chk("prio_mem_addr0", mem_addr, 32'h200);
    step();
    data_req = 1'b0;
    #1;
    chk("prio_inst_addr_ok1", inst_addr_ok, 1);
    chk("prio_mem_addr1", mem_addr, 32'h100);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    mem_data_ok = 1'b1; mem_rdata = 32'h11111111;
    #1;
    chk("rsp0_oks", {data_data_ok, inst_data_ok}, 2'b10);
    chk("rsp0_data_rdata", data_rdata, 32'h11111111);
    step();
    mem_rdata = 32'h22222222;
    #1;
    chk("rsp1_oks", {data_data_ok, inst_data_ok}, 2'b01);
    chk("rsp1_inst_rdata", inst_rdata, 32'h22222222);
    step();
    mem_data_ok = 1'b0;

    // Data store held unaccepted for 3 cycles; inst must not steal the port.
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h300; data_wdata = 32'hDEAD;
    #1;
    chk("lock_c0_addr", mem_addr, 32'h300);
    chk("lock_c0_addr_ok", data_addr_ok, 0);
    step();
    inst_req = 1'b1; inst_addr = 32'h104;
    for (int c = 1; c < 3; c++) begin
      #1;
      chk("lock_hold_addr", mem_addr, 32'h300);
      chk("lock_hold_wr_iok", {mem_wr, inst_addr_ok}, 2'b10);
      step();
    end
    mem_addr_ok = 1'b1;
    #1;
    chk("lock_accept", {data_addr_ok, inst_addr_ok}, 2'b10);
    chk("lock_accept_wdata", mem_wdata, 32'hDEAD);
    step();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0;
    #1;
    chk("lock_then_inst", {inst_addr_ok, mem_addr[11:0]}, {1'b1, 12'h104});
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    #1;
    chk("lock_rsp0", {data_data_ok, inst_data_ok}, 2'b10);
    step();
    #1;
    chk("lock_rsp1", {data_data_ok, inst_data_ok}, 2'b01);
    step();
    mem_data_ok = 1'b0;

    // Fill the order queue, then accept alongside a response.
    inst_req = 1'b1; inst_addr = 32'h108; mem_addr_ok = 1'b1;
    #1;
    chk("full_acc0", inst_addr_ok, 1);
    step();
    #1;
    chk("full_acc1", inst_addr_ok, 1);
    step();
    #1;
    chk("full_blocked", {mem_req, inst_addr_ok}, 2'b00);
    step();
    mem_data_ok = 1'b1; mem_rdata = 32'h33;
    #1;
    chk("full_pop_push", {mem_req, inst_addr_ok, inst_data_ok}, 3'b111);
    step();
    mem_data_ok = 1'b0;
    #1;
    chk("full_still", mem_req, 0);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("full_drain", inst_data_ok, 1);
      step();
    end
    #1;
    chk("empty_stray_rsp", {inst_data_ok, data_data_ok}, 2'b00);
    step();
    mem_data_ok = 1'b0;

    // Flush with two inst reads outstanding.
    inst_req = 1'b1; inst_addr = 32'h10C; mem_addr_ok = 1'b1;
    #1;
    chk("fl_acc0", inst_addr_ok, 1);
    step();
    #1;
    chk("fl_acc1", inst_addr_ok, 1);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; mem_data_ok = 1'b1;
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("fl_dropped", inst_data_ok, 0);
      step();
    end
    mem_data_ok = 1'b0; inst_req = 1'b1; inst_addr = 32'h110; mem_addr_ok = 1'b1;
    #1;
    chk("fl_refetch_acc", inst_addr_ok, 1);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'hABCD0000;
    #1;
    chk("fl_refetch_ok", inst_data_ok, 1);
    chk("fl_refetch_rdata", inst_rdata, 32'hABCD0000);
    step();
    mem_data_ok = 1'b0;

    // Store queued behind an inst read, then flush.
    inst_req = 1'b1; inst_addr = 32'h114; mem_addr_ok = 1'b1;
    #1;
    chk("mix_inst_acc", inst_addr_ok, 1);
    step();
    inst_req = 1'b0;
    data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011; data_addr = 32'h400; data_wdata = 32'h5555;
    #1;
    chk("mix_store_acc", {data_addr_ok, mem_wr, mem_wstrb}, {1'b1, 1'b1, 4'b0011});
    step();
    data_req = 1'b0; data_wr = 1'b0; data_wstrb = '0; mem_addr_ok = 1'b0; flush = 1'b1;
    step();
    flush = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h66;
    #1;
    chk("mix_inst_drop", {inst_data_ok, data_data_ok}, 2'b00);
    step();
    mem_rdata = 32'h77;
    #1;
    chk("mix_store_ok", {inst_data_ok, data_data_ok}, 2'b01);
    chk("mix_store_rdata", data_rdata, 32'h77);
    step();
    mem_data_ok = 1'b0;

    // Flush coincident with an inst accept marks that entry for discard.
    inst_req = 1'b1; mem_addr_ok = 1'b1; flush = 1'b1;
    #1;
    chk("flhs_acc", inst_addr_ok, 1);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; flush = 1'b0; mem_data_ok = 1'b1;
    #1;
    chk("flhs_drop", inst_data_ok, 0);
    step();
    mem_data_ok = 1'b0;

    // Reset mid-transaction: late response ignored.
    inst_req = 1'b1; mem_addr_ok = 1'b1;
    #1;
    chk("rstmid_acc", inst_addr_ok, 1);
    step();
    inst_req = 1'b0; mem_addr_ok = 1'b0; reset = 1'b1;
    step();
    reset = 1'b0; mem_data_ok = 1'b1;
    #1;
    chk("rstmid_late_rsp", {inst_data_ok, data_data_ok}, 2'b00);
    step();

    // Both requesting continuously with a response every cycle.
`ifdef ARB_ROUND_ROBIN_EN
    exp_rr = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
    exp_rr = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
    inst_req = 1'b1; data_req = 1'b1; data_wr = 1'b0; mem_addr_ok = 1'b1;
    for (int c = 0; c < 4; c++) begin
      #1;
      chk("arb_seq", {data_addr_ok, inst_addr_ok}, {exp_rr[c], ~exp_rr[c]});
      step();
    end
    inst_req = 1'b0; data_req = 1'b0; mem_addr_ok = 1'b0; mem_data_ok = 1'b0;
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
